// File: rtl/disparity_readout.sv
// disparity_readout: streams a finished disparity frame out of BRAM through a credit-controlled skid FIFO.
// Define DISPARITY_SCALE_EN to stretch disparities x4 (saturating at 255) before they enter the FIFO.
module disparity_readout #(
    parameter int IMG_W = 240,
    parameter int IMG_H = 320,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int AW = $clog2(IMG_W * IMG_H),
    localparam int XW = $clog2(IMG_W),
    localparam int YW = $clog2(IMG_H),
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk_100mhz,
    input  logic          sys_rst,
    input  logic          frame_done_in,
    input  logic [7:0]    ssd_dout,
    output logic          reading,
    output logic [AW-1:0] ssd_addr_out,
    output logic [7:0]    pixel_out,
    output logic          pixel_valid_out,
    input  logic          ready_in,
    output logic [XW-1:0] x_out,
    output logic [YW-1:0] y_out,
    output logic          last_out,
    output logic          frame_done_out
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    state_t state;
    logic pending;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [RD_LATENCY-1:0] dl_v;
    logic [RD_LATENCY-1:0] dl_l;
    logic [XW-1:0] dl_x [RD_LATENCY];
    logic [YW-1:0] dl_y [RD_LATENCY];
    logic [7:0] mem_pix [FIFO_DEPTH];
    logic [XW-1:0] mem_x [FIFO_DEPTH];
    logic [YW-1:0] mem_y [FIFO_DEPTH];
    logic mem_l [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] occupancy;
    logic [7:0] din;
    logic row_end;
    logic at_end;
    logic issue;
    logic push;
    logic pop;

    // Credit counts both stored entries and reads still in the BRAM pipe, so a push always has room.
    always_comb begin
        row_end = x == XW'(IMG_W - 1);
        at_end = row_end && y == YW'(IMG_H - 1);
        issue = state == READ && int'(occupancy) + $countones(dl_v) < FIFO_DEPTH;
        push = dl_v[RD_LATENCY-1];
        pop = pixel_valid_out && ready_in;
`ifdef DISPARITY_SCALE_EN
        din = ssd_dout[7:6] != 2'b00 ? 8'hff : {ssd_dout[5:0], 2'b00};
`else
        din = ssd_dout;
`endif
    end

    assign reading = state != IDLE;
    assign pixel_valid_out = occupancy != '0;
    assign pixel_out = pixel_valid_out ? mem_pix[rd_ptr] : '0;
    assign x_out = pixel_valid_out ? mem_x[rd_ptr] : '0;
    assign y_out = pixel_valid_out ? mem_y[rd_ptr] : '0;
    assign last_out = pixel_valid_out ? mem_l[rd_ptr] : 1'b0;

    always_ff @(posedge clk_100mhz) begin
        if (sys_rst) begin
            state <= IDLE;
            pending <= 1'b0;
            x <= '0;
            y <= '0;
            ssd_addr_out <= '0;
            dl_v <= '0;
            dl_l <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                dl_x[i] <= '0;
                dl_y[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occupancy <= '0;
            frame_done_out <= 1'b0;
        end else begin
            frame_done_out <= pop && last_out;
            if (state == IDLE && (frame_done_in || pending)) begin
                state <= READ;
                pending <= 1'b0;
            end else if (state == READ && issue && at_end) begin
                state <= DRAIN;
            end else if (state == DRAIN && frame_done_out && dl_v == '0 && occupancy == '0) begin
                state <= IDLE;
            end
            if (state != IDLE && frame_done_in)
                pending <= 1'b1;
            if (issue) begin
                ssd_addr_out <= at_end ? '0 : ssd_addr_out + 1'b1;
                x <= row_end ? '0 : x + 1'b1;
                y <= !row_end ? y : at_end ? '0 : y + 1'b1;
            end
            dl_v <= RD_LATENCY'({dl_v, issue});
            dl_l <= RD_LATENCY'({dl_l, issue && at_end});
            dl_x[0] <= x;
            dl_y[0] <= y;
            for (int i = 1; i < RD_LATENCY; i++) begin
                dl_x[i] <= dl_x[i-1];
                dl_y[i] <= dl_y[i-1];
            end
            if (push) begin
                mem_pix[wr_ptr] <= din;
                mem_x[wr_ptr] <= dl_x[RD_LATENCY-1];
                mem_y[wr_ptr] <= dl_y[RD_LATENCY-1];
                mem_l[wr_ptr] <= dl_l[RD_LATENCY-1];
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            occupancy <= occupancy + CW'(push) - CW'(pop);
        end
    end
endmodule
